maxpool_2x2_stream: RTL and testbench
=====================================

# maxpool_2x2_stream

Streaming 2×2, stride-2 max-pooling stage for IEEE-754 single-precision feature maps. It sits directly downstream of the 3×3 convolution stage inside the VGG16 block pipeline. It consumes one raster-order pixel per `valid_in` and emits one pooled pixel per completed 2×2 window, producing a `WIDTH/2 × HEIGHT/2` map. It uses a half-width line buffer, so no full-frame storage is required.

## Interface
- `DATA_WIDTH`, 32: pixel width; must be 32 (fp32).
- `WIDTH`, 56: input map width in pixels, ≥2.
- `HEIGHT`, 56: input map height in pixels, ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  `data_in` is a valid pixel this cycle.
- `data_in`  in  32  fp32 pixel, raster order (row-major, top-left first).
- `data_out`  out  32  pooled fp32 pixel (registered).
- `valid_out`  out  1  `data_out` is valid this cycle (one-cycle pulse per pooled pixel).
- `done`  out  1  one-cycle pulse coincident with the last `valid_out` of a frame.

## Operation
- Counters:
  - `col` runs 0..WIDTH-1 and `row` runs 0..HEIGHT-1.
  - Both advance only on cycles where `valid_in` = 1.
  - `col` wraps to 0 and increments `row` at the end of each line.
  - `row` wraps to 0 after the last line, so back-to-back frames need no re-arm.
- Phases within a line:
  - **EVEN_COL** (`col[0]`=0): latch `data_in` into the horizontal register `h`.
  - **ODD_COL** (`col[0]`=1): `hmax = fmax(h, data_in)`.
- Phases across rows:
  - **TOP_ROW** (`row[0]`=0): write `hmax` into `linebuf[col>>1]`. The line buffer has `WIDTH/2` entries.
  - **BOTTOM_ROW** (`row[0]`=1): register `fmax(linebuf[col>>1], hmax)` into `data_out` and assert `valid_out` next cycle.
- Odd dimensions use floor semantics:
  - With odd `WIDTH`, the pixel at `col = WIDTH-1` is accepted and discarded.
  - With odd `HEIGHT`, the whole row `HEIGHT-1` is accepted and discarded. No writes and no outputs occur for it.
- fmax rules (combinational comparator on raw bits):
  - Signs differ: the positive operand wins. +0 and −0 compare equal, and the first operand wins.
  - Both positive: the larger magnitude (bits[30:0]) wins.
  - Both negative: the smaller magnitude wins.
  - Equal values: the first operand wins.
  - NaN/Inf are not produced upstream. No special handling; the result is whatever the rules above give.
- Frame accounting: outputs per frame = `(WIDTH/2)·(HEIGHT/2)`. `done` pulses with the output whose window covers `row = 2·(HEIGHT/2)-1` and `col = 2·(WIDTH/2)-1`.

## Timing
- Reset values: `data_out` = 0, `valid_out` = 0, `done` = 0, `col` = `row` = 0, `h` = 0.
  - Line buffer contents are don't-care; every entry is written on a top row before it is read.
- Latency: `valid_out` rises exactly 1 cycle after the accepting edge of the bottom-right pixel of a window.
- `valid_out` is high for exactly one cycle per pooled pixel and never on consecutive cycles from the same line position.
- No backpressure: the block always accepts `valid_in`. Gaps (`valid_in` = 0) freeze counters, `h`, and the line buffer.
- `reset` asserted mid-frame: on the next edge, counters are zeroed and outputs cleared. A pending output from the same edge is suppressed. The next accepted pixel is treated as `row` 0, `col` 0.
- Line-buffer read and write are to the same index on different row parities. No read-during-write hazard exists within a cycle.
- Frame boundary: the last pixel of frame N and the first pixel of frame N+1 may be on consecutive cycles. `done` is asserted for frame N only, and frame N+1 proceeds normally.

## Test plan
- **Positive ramp:** `WIDTH`=`HEIGHT`=4, inputs 1.0..16.0 (0x3f800000..0x41800000) on consecutive cycles.
  - Expect `data_out` = 0x40c00000, 0x41000000, 0x41600000, 0x41800000 (6, 8, 14, 16).
  - Each output appears 1 cycle after inputs #6, #8, #14, #16. `done` pulses with the 16.0 output.
- **Negative ramp:** same dimensions, inputs −1.0..−16.0.
  - Expect 0xbf800000, 0xc0400000, 0xc1100000, 0xc1300000 (−1, −3, −9, −11).
- **Signed zero and mixed signs:** window {0x80000000, 0x00000000, 0xbf800000, 0x80000000}.
  - Expect output 0x80000000 (first operand wins on the equal zeros).
  - A window {−2.0, 0.5, −3.0, −1.0} gives 0x3f000000.
- **Throttled input:** repeat the positive ramp with `valid_in` deasserted every other cycle.
  - Expect identical values and `done`, each output still 1 cycle after its triggering pixel.
- **Odd dimensions:** `WIDTH`=`HEIGHT`=5, inputs 1.0..25.0.
  - Expect exactly 4 outputs: 7, 9, 17, 19 (0x40e00000, 0x41100000, 0x41880000, 0x41980000).
  - `done` pulses with 19. No output occurs for row 4 or column 4.
- **Reset mid-frame and back-to-back frames:** assert `reset` for 1 cycle after pixel #7 of a 4×4 frame.
  - Expect no further outputs from that frame.
  - Then send two back-to-back positive ramps. Expect 8 outputs and 2 `done` pulses, matching the positive-ramp case per frame.

Source files
------------

// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream: streaming 2x2/stride-2 fp32 max-pool (clk, reset, valid_in, data_in -> data_out, valid_out, done) using a WIDTH/2-entry line buffer
module maxpool_2x2_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  done
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int HW = WIDTH / 2;
  localparam int AW = HW > 1 ? $clog2(HW) : 1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DATA_WIDTH-1:0] h, hmax, vmax;
  logic [DATA_WIDTH-1:0] linebuf [HW];
  logic [AW-1:0] idx;
  logic col_end, row_end, row_live, last;
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    return (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
      ? ((a[DATA_WIDTH-2:0] == '0 && b[DATA_WIDTH-2:0] == '0) ? a : (a[DATA_WIDTH-1] ? b : a))
      : (a[DATA_WIDTH-1] ? ((b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0]) ? b : a)
                         : ((b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) ? b : a));
  endfunction
  always_comb begin
    idx      = AW'(col >> 1);
    hmax     = fmax(h, data_in);
    vmax     = fmax(linebuf[idx], hmax);
    col_end  = col == CW'(WIDTH - 1);
    row_end  = row == RW'(HEIGHT - 1);
    row_live = (HEIGHT % 2 == 0) || !row_end;
    last     = (row == RW'(2 * (HEIGHT / 2) - 1)) && (col == CW'(2 * (WIDTH / 2) - 1));
  end
  always_ff @(posedge clk)
    if (!reset && valid_in && col[0] && !row[0] && row_live) linebuf[idx] <= hmax;
  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      h         <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      done      <= 1'b0;
      if (valid_in) begin
        col <= col_end ? '0 : col + 1'b1;
        row <= col_end ? (row_end ? '0 : row + 1'b1) : row;
        if (!col[0]) h <= data_in;
        if (col[0] && row[0]) begin
          data_out  <= vmax;
          valid_out <= 1'b1;
          done      <= last;
        end
      end
    end
  end
endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// tb_maxpool_2x2_stream: table-driven, scoreboarded bench for 4x4 and 5x5 max-pool instances
module tb_maxpool_2x2_stream;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic v4 = 1'b0, v5 = 1'b0;
  logic [31:0] x4 = '0, x5 = '0, d4, d5;
  logic o4, o5, dn4, dn5;
  maxpool_2x2_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) u4 (
    .clk(clk), .reset(reset), .valid_in(v4), .data_in(x4),
    .data_out(d4), .valid_out(o4), .done(dn4));
  maxpool_2x2_stream #(.DATA_WIDTH(32), .WIDTH(5), .HEIGHT(5)) u5 (
    .clk(clk), .reset(reset), .valid_in(v5), .data_in(x5),
    .data_out(d5), .valid_out(o5), .done(dn5));
  typedef struct {logic [31:0] din; logic ev; logic [31:0] ed; logic edn;} vec_t;
  typedef struct {int sel; logic [31:0] d; logic dn; int due;} exp_t;
  vec_t tbl[$];
  exp_t q[$];
  int cyc = 0, n_vec = 0, n_bad = 0;
  logic [31:0] pos_e [4] = '{32'h40c00000, 32'h41000000, 32'h41600000, 32'h41800000};
  logic [31:0] neg_e [4] = '{32'hbf800000, 32'hc0400000, 32'hc1100000, 32'hc1300000};
  logic [31:0] odd_e [4] = '{32'h40e00000, 32'h41100000, 32'h41880000, 32'h41980000};
  logic [31:0] mix [8] = '{32'h80000000, 32'h00000000, 32'hc0000000, 32'h3f000000,
                           32'hbf800000, 32'h80000000, 32'hc0400000, 32'hbf800000};
  int p4 [4] = '{6, 8, 14, 16};
  int p5 [4] = '{7, 9, 17, 19};
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] f32(input int n);
    int m = n < 0 ? -n : n;
    int p = 0;
    for (int i = 0; i < 31; i++) if ((m >> i) != 0) p = i;
    return {n < 0, 8'(127 + p), 23'((m << (23 - p)) & 32'h7fffff)};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic [31:0] din, input logic ev, input logic [31:0] ed, input logic edn);
    tbl.push_back('{din, ev, ed, edn});
  endtask
  task automatic ramp(input int n, input int sgn, input logic [31:0] e [4], input int p [4]);
    for (int i = 1; i <= n; i++) begin
      int j = -1;
      for (int k = 0; k < 4; k++) if (p[k] == i) j = k;
      add(f32(sgn * i), j >= 0, j >= 0 ? e[j] : 32'h0, j == 3);
    end
  endtask
  task automatic drive(input int k, input logic v, input logic [31:0] x);
    if (k == 0) begin v4 = v; x4 = x; end
    else begin v5 = v; x5 = x; end
  endtask
  task automatic apply(input int k, input int gap);
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(k, 1'b1, tbl[i].din);
      if (tbl[i].ev) q.push_back('{k, tbl[i].ed, tbl[i].edn, cyc + 1});
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        drive(k, 1'b0, 32'h0);
      end
    end
    @(negedge clk);
    drive(k, 1'b0, 32'h0);
    tbl.delete();
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic ov, odn;
      logic [31:0] od;
      exp_t e;
      ov  = k == 0 ? o4 : o5;
      odn = k == 0 ? dn4 : dn5;
      od  = k == 0 ? d4 : d5;
      if (q.size() > 0 && q[0].sel == k && q[0].due < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL missed_output dut%0d: no valid_out at cycle %0d, expected data %h", k, q[0].due, q[0].d);
        void'(q.pop_front());
      end
      if (ov) begin
        if (q.size() == 0 || q[0].sel != k) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output dut%0d: got valid_out data %h at cycle %0d, expected none", k, od, cyc);
        end else begin
          e = q.pop_front();
          check($sformatf("data dut%0d", k), od, e.d);
          check($sformatf("done dut%0d", k), {31'h0, odn}, {31'h0, e.dn});
          check($sformatf("latency dut%0d", k), cyc, e.due);
        end
      end else if (odn) begin
        n_vec++;
        n_bad++;
        $display("FAIL done_without_valid dut%0d: got done=1 expected 0 at cycle %0d", k, cyc);
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst data_out4", d4, 32'h0);
    check("rst valid_out4", {31'h0, o4}, 32'h0);
    check("rst done4", {31'h0, dn4}, 32'h0);
    check("rst data_out5", d5, 32'h0);
    check("rst valid_out5", {31'h0, o5}, 32'h0);
    check("rst done5", {31'h0, dn5}, 32'h0);
    reset = 1'b0;
    ramp(16, 1, pos_e, p4);
    apply(0, 0);
    ramp(16, -1, neg_e, p4);
    apply(0, 0);
    for (int i = 0; i < 16; i++)
      add(mix[i % 8], (i % 8 == 5) || (i % 8 == 7), (i % 8 == 5) ? 32'h80000000 : 32'h3f000000, i == 15);
    apply(0, 0);
    ramp(16, 1, pos_e, p4);
    apply(0, 1);
    ramp(25, 1, odd_e, p5);
    apply(1, 0);
    ramp(7, 1, pos_e, p4);
    apply(0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst data_out", d4, 32'h0);
    ramp(5, 1, pos_e, p4);
    apply(0, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b1, f32(6));
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b0, 32'h0);
    check("rst_with_pixel valid_out", {31'h0, o4}, 32'h0);
    check("rst_with_pixel data_out", d4, 32'h0);
    ramp(16, 1, pos_e, p4);
    ramp(16, 1, pos_e, p4);
    apply(0, 0);
    repeat (5) @(negedge clk);
    check("scoreboard_empty", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
